// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, base address and FSM encoding.
package dmem_arbiter_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] MEM_BASE_DEF = 32'h8000_0000;
    localparam int unsigned RD_CTRL_W    = 3;
    localparam int unsigned WR_CTRL_W    = 2;

    typedef enum logic {
        CpuOwn  = 1'b0,
        DbgResp = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating starvation counter: synchronous clear has priority over increment.
module dmem_arb_starve_cnt #(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] LimitC = W'(LIMIT);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != LimitC)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the data-SRAM port between the execute stage (default owner) and a debug/DMA master,
// with a starvation counter that forces a one-cycle CPU stall to let debug through.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter int unsigned     STARVE_LIMIT = 4,
    parameter logic [XLEN-1:0] MEM_BASE     = XLEN'(MEM_BASE_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_valid,
    input  logic [RD_CTRL_W-1:0] cpu_rd_ctrl,
    input  logic [WR_CTRL_W-1:0] cpu_wr_ctrl,
    input  logic [XLEN-1:0]      cpu_addr,
    input  logic [XLEN-1:0]      cpu_wdata,
    output logic [XLEN-1:0]      cpu_rdata,
    output logic                 cpu_stall,
    input  logic                 dbg_req_valid,
    output logic                 dbg_req_ready,
    input  logic [RD_CTRL_W-1:0] dbg_req_rd_ctrl,
    input  logic [WR_CTRL_W-1:0] dbg_req_wr_ctrl,
    input  logic [XLEN-1:0]      dbg_req_addr,
    input  logic [XLEN-1:0]      dbg_req_wdata,
    output logic                 dbg_resp_valid,
    input  logic                 dbg_resp_ready,
    output logic [XLEN-1:0]      dbg_resp_rdata,
    output logic [RD_CTRL_W-1:0] sram_rd_ctrl,
    output logic [WR_CTRL_W-1:0] sram_wr_ctrl,
    output logic [XLEN-1:0]      sram_addr,
    output logic [XLEN-1:0]      sram_wdata,
    input  logic [XLEN-1:0]      sram_rdata
);

    localparam int unsigned     CntW   = ($clog2(STARVE_LIMIT + 1) > 0) ?
                                         $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] LimitC = CntW'(STARVE_LIMIT);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] starve_cnt;
    logic            cnt_clr, cnt_inc;
    logic            cpu_access, grant;
    logic [XLEN-1:0] resp_rdata_q;

    assign cpu_access = cpu_valid && ((|cpu_rd_ctrl) || (|cpu_wr_ctrl));
    assign grant      = (state_q == CpuOwn) && dbg_req_valid &&
                        (!cpu_access || (starve_cnt == LimitC));

    dmem_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .W     (CntW)
    ) u_starve_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (starve_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CpuOwn;
            resp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                resp_rdata_q <= (|dbg_req_rd_ctrl) ? sram_rdata : '0;
            end
        end
    end

    always_comb begin
        // CPU owns the port unless a grant overrides it; stores are gated so a stall drops them.
        sram_rd_ctrl  = cpu_rd_ctrl;
        sram_wr_ctrl  = cpu_access ? cpu_wr_ctrl : '0;
        sram_addr     = cpu_access ? cpu_addr : MEM_BASE;
        sram_wdata    = cpu_wdata;
        dbg_req_ready = 1'b0;
        cpu_stall     = 1'b0;
        cnt_clr       = 1'b0;
        cnt_inc       = 1'b0;
        state_d       = state_q;

        unique case (state_q)
            CpuOwn: begin
                if (grant) begin
                    sram_rd_ctrl  = dbg_req_rd_ctrl;
                    sram_wr_ctrl  = dbg_req_wr_ctrl;
                    sram_addr     = dbg_req_addr;
                    sram_wdata    = dbg_req_wdata;
                    dbg_req_ready = 1'b1;
                    cpu_stall     = cpu_access;
                    cnt_clr       = 1'b1;
                    state_d       = DbgResp;
                end else begin
                    cnt_inc = dbg_req_valid;
                end
            end
            DbgResp: begin
                if (dbg_resp_ready) begin
                    state_d = CpuOwn;
                end
            end
            default: state_d = CpuOwn;
        endcase
    end

    assign cpu_rdata      = sram_rdata;
    assign dbg_resp_valid = (state_q == DbgResp);
    assign dbg_resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: STARVE_LIMIT=4 main instance plus a STARVE_LIMIT=0 instance.
module tb_dmem_arbiter;

    localparam logic [31:0] MemBase = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid;
    logic [2:0]  cpu_rd_ctrl;
    logic [1:0]  cpu_wr_ctrl;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req_valid, dbg_req_ready;
    logic [2:0]  dbg_req_rd_ctrl;
    logic [1:0]  dbg_req_wr_ctrl;
    logic [31:0] dbg_req_addr, dbg_req_wdata;
    logic        dbg_resp_valid, dbg_resp_ready;
    logic [31:0] dbg_resp_rdata;
    logic [2:0]  sram_rd_ctrl;
    logic [1:0]  sram_wr_ctrl;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    // Outputs of the STARVE_LIMIT=0 instance
    logic [31:0] z_cpu_rdata, z_dbg_resp_rdata, z_sram_addr, z_sram_wdata;
    logic        z_cpu_stall, z_dbg_req_ready, z_dbg_resp_valid;
    logic [2:0]  z_sram_rd_ctrl;
    logic [1:0]  z_sram_wr_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .XLEN         (32),
        .STARVE_LIMIT (4),
        .MEM_BASE     (MemBase)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_valid       (cpu_valid),
        .cpu_rd_ctrl     (cpu_rd_ctrl),
        .cpu_wr_ctrl     (cpu_wr_ctrl),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .cpu_stall       (cpu_stall),
        .dbg_req_valid   (dbg_req_valid),
        .dbg_req_ready   (dbg_req_ready),
        .dbg_req_rd_ctrl (dbg_req_rd_ctrl),
        .dbg_req_wr_ctrl (dbg_req_wr_ctrl),
        .dbg_req_addr    (dbg_req_addr),
        .dbg_req_wdata   (dbg_req_wdata),
        .dbg_resp_valid  (dbg_resp_valid),
        .dbg_resp_ready  (dbg_resp_ready),
        .dbg_resp_rdata  (dbg_resp_rdata),
        .sram_rd_ctrl    (sram_rd_ctrl),
        .sram_wr_ctrl    (sram_wr_ctrl),
        .sram_addr       (sram_addr),
        .sram_wdata      (sram_wdata),
        .sram_rdata      (sram_rdata)
    );

    dmem_arbiter #(
        .XLEN         (32),
        .STARVE_LIMIT (0),
        .MEM_BASE     (MemBase)
    ) dut0 (
        .clk             (clk),
        .rst             (rst),
        .cpu_valid       (cpu_valid),
        .cpu_rd_ctrl     (cpu_rd_ctrl),
        .cpu_wr_ctrl     (cpu_wr_ctrl),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (z_cpu_rdata),
        .cpu_stall       (z_cpu_stall),
        .dbg_req_valid   (dbg_req_valid),
        .dbg_req_ready   (z_dbg_req_ready),
        .dbg_req_rd_ctrl (dbg_req_rd_ctrl),
        .dbg_req_wr_ctrl (dbg_req_wr_ctrl),
        .dbg_req_addr    (dbg_req_addr),
        .dbg_req_wdata   (dbg_req_wdata),
        .dbg_resp_valid  (z_dbg_resp_valid),
        .dbg_resp_ready  (dbg_resp_ready),
        .dbg_resp_rdata  (z_dbg_resp_rdata),
        .sram_rd_ctrl    (z_sram_rd_ctrl),
        .sram_wr_ctrl    (z_sram_wr_ctrl),
        .sram_addr       (z_sram_addr),
        .sram_wdata      (z_sram_wdata),
        .sram_rdata      (sram_rdata)
    );

    // Inputs change 1 time unit after the rising edge; checks sample 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_valid = 0; cpu_rd_ctrl = 0; cpu_wr_ctrl = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req_valid = 0; dbg_req_rd_ctrl = 0; dbg_req_wr_ctrl = 0;
        dbg_req_addr = 0; dbg_req_wdata = 0; dbg_resp_ready = 0; sram_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (dbg_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset resp_valid: got %b want 0", dbg_resp_valid); end
        n_checks++; if (dbg_resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset resp_rdata: got %h want 0", dbg_resp_rdata); end
        n_checks++; if (dbg_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset req_ready: got %b want 0", dbg_req_ready); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset cpu_stall: got %b want 0", cpu_stall); end
        n_checks++; if (sram_wr_ctrl !== 2'b00) begin n_fail++; $display("FAIL reset sram_wr_ctrl: got %b want 00", sram_wr_ctrl); end
        n_checks++; if (sram_rd_ctrl !== 3'b000) begin n_fail++; $display("FAIL reset sram_rd_ctrl: got %b want 000", sram_rd_ctrl); end
        n_checks++; if (sram_addr !== MemBase) begin n_fail++; $display("FAIL reset sram_addr: got %h want %h", sram_addr, MemBase); end
        n_checks++; if (dut.starve_cnt !== 3'd0) begin n_fail++; $display("FAIL reset starve_cnt: got %0d want 0", dut.starve_cnt); end
    endtask

    task automatic test_cpu_only();
        cpu_valid = 1; cpu_rd_ctrl = 3'b010; cpu_addr = 32'h8000_0010; sram_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cpu_only rdata: got %h want deadbeef", cpu_rdata); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_only stall: got %b want 0", cpu_stall); end
        n_checks++; if (sram_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL cpu_only sram_addr: got %h want 80000010", sram_addr); end
        n_checks++; if (sram_rd_ctrl !== 3'b010) begin n_fail++; $display("FAIL cpu_only sram_rd_ctrl: got %b want 010", sram_rd_ctrl); end
        n_checks++; if (dbg_req_ready !== 1'b0 || dbg_resp_valid !== 1'b0) begin n_fail++; $display("FAIL cpu_only dbg_idle: got ready=%b resp_valid=%b want 0 0", dbg_req_ready, dbg_resp_valid); end
        step();
        idle_inputs();
    endtask

    task automatic test_dbg_idle_cpu();
        dbg_req_valid = 1; dbg_req_rd_ctrl = 3'b010; dbg_req_addr = 32'h8000_0100;
        sram_rdata = 32'h1234_5678;
        #1;
        n_checks++; if (dbg_req_ready !== 1'b1) begin n_fail++; $display("FAIL dbg_idle req_ready: got %b want 1", dbg_req_ready); end
        n_checks++; if (sram_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL dbg_idle sram_addr: got %h want 80000100", sram_addr); end
        n_checks++; if (sram_rd_ctrl !== 3'b010) begin n_fail++; $display("FAIL dbg_idle sram_rd_ctrl: got %b want 010", sram_rd_ctrl); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL dbg_idle stall: got %b want 0", cpu_stall); end
        step();
        dbg_req_valid = 0; dbg_req_rd_ctrl = 0; sram_rdata = 32'h0;
        #1;
        n_checks++; if (dbg_resp_valid !== 1'b1) begin n_fail++; $display("FAIL dbg_idle resp_valid: got %b want 1", dbg_resp_valid); end
        n_checks++; if (dbg_resp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL dbg_idle resp_rdata: got %h want 12345678", dbg_resp_rdata); end
        dbg_resp_ready = 1;
        step();
        dbg_resp_ready = 0;
        #1;
        n_checks++; if (dbg_resp_valid !== 1'b0) begin n_fail++; $display("FAIL dbg_idle resp_drop: got %b want 0", dbg_resp_valid); end
    endtask

    task automatic test_starvation();
        cpu_valid = 1; cpu_wr_ctrl = 2'b10; cpu_addr = 32'h8000_0020; cpu_wdata = 32'hAAAA_AAAA;
        dbg_req_valid = 1; dbg_req_wr_ctrl = 2'b01; dbg_req_addr = 32'h8000_0200;
        dbg_req_wdata = 32'h5555_5555;
        for (int c = 1; c <= 4; c++) begin
            #1;
            n_checks++; if (dbg_req_ready !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL starve cyc%0d blocked: got ready=%b stall=%b want 0 0", c, dbg_req_ready, cpu_stall); end
            n_checks++; if (sram_wr_ctrl !== 2'b10 || sram_addr !== 32'h8000_0020) begin n_fail++; $display("FAIL starve cyc%0d cpu_port: got wr=%b addr=%h want 10 80000020", c, sram_wr_ctrl, sram_addr); end
            step();
        end
        #1;
        n_checks++; if (dut.starve_cnt !== 3'd4) begin n_fail++; $display("FAIL starve cnt_sat: got %0d want 4", dut.starve_cnt); end
        n_checks++; if (dbg_req_ready !== 1'b1 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL starve grant: got ready=%b stall=%b want 1 1", dbg_req_ready, cpu_stall); end
        n_checks++; if (sram_wr_ctrl !== 2'b01 || sram_addr !== 32'h8000_0200 || sram_wdata !== 32'h5555_5555) begin n_fail++; $display("FAIL starve dbg_port: got wr=%b addr=%h wd=%h want 01 80000200 55555555", sram_wr_ctrl, sram_addr, sram_wdata); end
        step();
        dbg_req_valid = 0; dbg_req_wr_ctrl = 0;
        #1;
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL starve stall_one_cycle: got %b want 0", cpu_stall); end
        n_checks++; if (sram_wr_ctrl !== 2'b10 || sram_addr !== 32'h8000_0020 || sram_wdata !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL starve cpu_replay: got wr=%b addr=%h wd=%h want 10 80000020 aaaaaaaa", sram_wr_ctrl, sram_addr, sram_wdata); end
        n_checks++; if (dbg_resp_valid !== 1'b1 || dbg_resp_rdata !== 32'h0) begin n_fail++; $display("FAIL starve write_resp: got v=%b d=%h want 1 0", dbg_resp_valid, dbg_resp_rdata); end
        n_checks++; if (dut.starve_cnt !== 3'd0) begin n_fail++; $display("FAIL starve cnt_clear: got %0d want 0", dut.starve_cnt); end
        dbg_resp_ready = 1;
        step();
        idle_inputs();
    endtask

    task automatic test_backpressure();
        dbg_req_valid = 1; dbg_req_rd_ctrl = 3'b100; dbg_req_addr = 32'h8000_0300;
        sram_rdata = 32'hCAFE_F00D;
        #1;
        n_checks++; if (dbg_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp first_grant: got %b want 1", dbg_req_ready); end
        step();
        dbg_req_addr = 32'h8000_0304; sram_rdata = 32'h0BAD_0BAD;
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_checks++; if (dbg_resp_valid !== 1'b1 || dbg_resp_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL bp hold%0d: got v=%b d=%h want 1 cafef00d", c, dbg_resp_valid, dbg_resp_rdata); end
            n_checks++; if (dbg_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp blocked%0d: got %b want 0", c, dbg_req_ready); end
            step();
        end
        dbg_resp_ready = 1;
        #1;
        n_checks++; if (dbg_req_ready !== 1'b0 || dbg_resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp consume_cycle: got ready=%b v=%b want 0 1", dbg_req_ready, dbg_resp_valid); end
        step();
        dbg_resp_ready = 0;
        #1;
        n_checks++; if (dbg_req_ready !== 1'b1 || dbg_resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp second_grant: got ready=%b v=%b want 1 0", dbg_req_ready, dbg_resp_valid); end
        step();
        dbg_req_valid = 0; dbg_req_rd_ctrl = 0;
        #1;
        n_checks++; if (dbg_resp_rdata !== 32'h0BAD_0BAD) begin n_fail++; $display("FAIL bp second_data: got %h want 0bad0bad", dbg_resp_rdata); end
        dbg_resp_ready = 1;
        step();
        idle_inputs();
    endtask

    task automatic test_cnt_hold();
        cpu_valid = 1; cpu_rd_ctrl = 3'b001; cpu_addr = 32'h8000_0040;
        dbg_req_valid = 1; dbg_req_rd_ctrl = 3'b001; dbg_req_addr = 32'h8000_0400;
        step();
        step();
        dbg_req_valid = 0;
        step();
        #1;
        n_checks++; if (dut.starve_cnt !== 3'd2) begin n_fail++; $display("FAIL cnt_hold: got %0d want 2", dut.starve_cnt); end
        idle_inputs();
    endtask

    task automatic test_limit0();
        do_reset();
        cpu_valid = 1; cpu_rd_ctrl = 3'b010; cpu_addr = 32'h8000_0050;
        dbg_req_valid = 1; dbg_req_rd_ctrl = 3'b010; dbg_req_addr = 32'h8000_0500;
        #1;
        n_checks++; if (z_dbg_req_ready !== 1'b1 || z_cpu_stall !== 1'b1) begin n_fail++; $display("FAIL limit0 grant: got ready=%b stall=%b want 1 1", z_dbg_req_ready, z_cpu_stall); end
        n_checks++; if (z_sram_addr !== 32'h8000_0500) begin n_fail++; $display("FAIL limit0 sram_addr: got %h want 80000500", z_sram_addr); end
        n_checks++; if (dbg_req_ready !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL limit4 no_grant: got ready=%b stall=%b want 0 0", dbg_req_ready, cpu_stall); end
        n_checks++; if (dut0.starve_cnt !== 1'b0) begin n_fail++; $display("FAIL limit0 cnt: got %0d want 0", dut0.starve_cnt); end
        idle_inputs();
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        dbg_req_valid = 1; dbg_req_rd_ctrl = 3'b010; dbg_req_addr = 32'h8000_0600;
        sram_rdata = 32'h7777_7777;
        step();
        dbg_req_valid = 0; dbg_req_rd_ctrl = 0;
        #1;
        n_checks++; if (dbg_resp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_resp pre: got %b want 1", dbg_resp_valid); end
        rst = 1;
        step();
        rst = 0;
        #1;
        n_checks++; if (dbg_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp resp_valid: got %b want 0", dbg_resp_valid); end
        n_checks++; if (dut.starve_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_resp cnt: got %0d want 0", dut.starve_cnt); end
        n_checks++; if (sram_addr !== MemBase) begin n_fail++; $display("FAIL rst_resp sram_addr: got %h want %h", sram_addr, MemBase); end
        n_checks++; if (dbg_resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp rdata: got %h want 0", dbg_resp_rdata); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_cpu_only();
        test_dbg_idle_cpu();
        test_starvation();
        test_backpressure();
        test_cnt_hold();
        test_limit0();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
